servo_pwm_driver: RTL and testbench
===================================

// Module: servo_pwm_driver
// PURPOSE
//  Converts the PID stage's 8-bit angle command (degrees) into a hobby-servo PWM waveform.
//  Frame rate is fixed; pulse width is linear in angle.
//  Command is clamped, slew-limited and sampled once per frame, so the pulse never glitches mid-frame.
//  Sits directly downstream of the PID controller and drives the control-surface servo pin.
// PARAMETERS
//  CLK_HZ      50_000_000  clock frequency; must be an integer multiple of 1_000_000
//  FRAME_US    20000       PWM frame period, microseconds
//  MIN_US      1000        pulse width at 0 deg, us (>=1)
//  MAX_US      2000        pulse width at MAX_DEG, us (<FRAME_US)
//  MAX_DEG     180         largest legal angle; larger commands are clamped
//  SLEW_STEP   0           max deg change of applied angle per frame; 0 = unlimited
// PORTS
//  clk          in   1  system clock
//  rst          in   1  synchronous, active-high reset
//  enable       in   1  1 = generate frames; 0 = output idle low
//  position     in   8  commanded angle, unsigned degrees
//  pwm_out      out  1  servo PWM
//  frame_start  out  1  1-cycle pulse on the cycle pwm_out rises
//  applied_pos  out  8  angle used for the current frame
//  clamped      out  1  current frame's sample exceeded MAX_DEG
// BEHAVIOUR
//  - Reset (sampled on clk): pwm_out=0, frame_start=0, clamped=0, applied_pos=MAX_DEG/2 (90).
//    Reset also zeroes both counters and sets state IDLE. Reset mid-frame aborts the pulse next cycle.
//  - TICKS=CLK_HZ/1e6. us prescaler counts 0..TICKS-1; frame counter counts us 0..FRAME_US-1 (wraps).
//  - Boundary cycle B: prescaler==0 AND frame counter==0 AND enable=1 AND rst=0.
//    At the edge ending B:
//    - target = min(position, MAX_DEG). clamped <= (position > MAX_DEG).
//    - Slew: if SLEW_STEP!=0, applied_pos moves toward target by min(|target-applied|, SLEW_STEP).
//      Otherwise applied_pos <= target.
//    - pulse_us = MIN_US + floor(new_applied*(MAX_US-MIN_US)/MAX_DEG). Intermediate product >=18 bits, unsigned.
//    - pwm_out <= 1, frame_start <= 1 (cleared next cycle), state HIGH.
//  - HIGH: pwm_out stays 1 for exactly pulse_us*TICKS cycles, then state LOW with pwm_out=0.
//  - LOW: pwm_out held 0 until the counters wrap to the next boundary cycle.
//    Frame period is exactly FRAME_US*TICKS cycles.
//  - position is ignored outside boundary cycles. applied_pos and clamped are constant within a frame.
//  - enable sampled 0 (any state): next cycle pwm_out=0 and counters=0; state IDLE.
//    Counters hold at 0 while enable=0. applied_pos and clamped are retained.
//    The first cycle with enable=1 is a boundary cycle.
//  - rst has priority over enable. Position 0 gives pulse MIN_US; MAX_DEG gives exactly MAX_US.
//  - States: IDLE -(enable)-> boundary -> HIGH -(pulse done)-> LOW -(wrap)-> HIGH ...;
//    any state -(!enable)-> IDLE; any state -(rst)-> IDLE.
// TESTING  (CLK_HZ=1_000_000 so TICKS=1)
//  1. rst, then enable=1, position=90 -> pwm_out high 1500 cycles, low 18500.
//     frame_start every 20000 cycles; applied_pos=90.
//  2. position=200, SLEW_STEP=0 -> next frame: clamped=1, applied_pos=180, pulse 2000.
//     Then position=0 -> clamped=0, pulse 1000.
//  3. SLEW_STEP=4, applied 90, position=100 -> applied 94, 98, 100 on successive frames.
//     Pulses 1522, 1544, 1555.
//  4. position 90->30 at cycle 700 of a 1500 pulse -> current pulse stays 1500; next frame pulse 1166.
//  5. enable=0 at cycle 300 of pulse -> pwm_out 0 next cycle, no frame_start while low.
//     Re-enable -> frame_start on the following edge with the old applied_pos kept.
//  6. rst asserted mid-pulse with applied_pos=150 -> next cycle pwm_out=0 and applied_pos=90.
//     After release, first frame pulse 1500.

Source files
------------

// File: rtl/servo_pwm_driver.sv
`default_nettype none
// ============================================================================
//  Module   : servo_pwm_driver
//  Purpose  : Turns an 8-bit angle command (degrees) into a hobby-servo PWM
//             waveform. The frame period is fixed and the pulse width is
//             linear in angle. The command is clamped to MAX_DEG,
//             slew-limited, and sampled once per frame, so a pulse never
//             changes width part-way through.
//  Ports    : clk          in   system clock
//             rst          in   synchronous active-high reset
//             enable       in   1 = generate frames, 0 = idle low
//             position     in   [7:0] commanded angle, unsigned degrees
//             pwm_out      out  servo PWM
//             frame_start  out  1-cycle pulse on the cycle pwm_out rises
//             applied_pos  out  [7:0] angle used for the current frame
//             clamped      out  current frame's sample exceeded MAX_DEG
//  Revision : 1.0  initial release
// ============================================================================
module servo_pwm_driver #(
   parameter int CLK_HZ    = 50_000_000,
   parameter int FRAME_US  = 20000,
   parameter int MIN_US    = 1000,
   parameter int MAX_US    = 2000,
   parameter int MAX_DEG   = 180,
   parameter int SLEW_STEP = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       enable,
   input  logic [7:0] position,
   output logic       pwm_out,
   output logic       frame_start,
   output logic [7:0] applied_pos,
   output logic       clamped
);

   localparam int TICKS = CLK_HZ / 1_000_000;
   localparam int PW    = (TICKS > 1) ? $clog2(TICKS) : 1;
   localparam int FW    = (FRAME_US > 1) ? $clog2(FRAME_US) : 1;
   localparam int HW    = $clog2(MAX_US * TICKS + 1);

   localparam logic [PW-1:0] PRE_LAST   = PW'(TICKS - 1);
   localparam logic [FW-1:0] FRAME_LAST = FW'(FRAME_US - 1);
   localparam logic [7:0]    MAX_DEG8   = 8'(MAX_DEG);
   localparam logic [7:0]    STEP8      = 8'(SLEW_STEP);
   localparam logic [7:0]    MID_DEG8   = 8'(MAX_DEG / 2);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HIGH = 2'd1,
      LOW  = 2'd2
   } state_t;

   state_t          state;
   state_t          state_next;
   logic [PW-1:0]   pre_cnt;
   logic [FW-1:0]   us_cnt;
   logic [HW-1:0]   high_cnt;

   logic            boundary;
   logic [7:0]      target;
   logic [7:0]      diff;
   logic [7:0]      next_applied;
   logic [31:0]     prod;
   logic [31:0]     pulse_us;
   logic [HW-1:0]   high_load;

   // Counters sit at zero whenever enable was low, so the first enabled
   // cycle is automatically a frame boundary.
   assign boundary = enable && (pre_cnt == '0) && (us_cnt == '0);

   // Target angle, slew limiting and the resulting high-time load value.
   always_comb begin
      target       = (position > MAX_DEG8) ? MAX_DEG8 : position;
      diff         = 8'd0;
      next_applied = target;
      if (STEP8 != 8'd0) begin
         if (target >= applied_pos) begin
            diff         = target - applied_pos;
            next_applied = applied_pos + ((diff > STEP8) ? STEP8 : diff);
         end else begin
            diff         = applied_pos - target;
            next_applied = applied_pos - ((diff > STEP8) ? STEP8 : diff);
         end
      end
      prod      = 32'(next_applied) * 32'(MAX_US - MIN_US);
      pulse_us  = 32'(MIN_US) + (prod / 32'(MAX_DEG));
      // high_cnt counts down to zero inclusive, hence the -1.
      high_load = HW'(pulse_us * 32'(TICKS) - 32'd1);
   end

   // Next-state logic.
   always_comb begin
      state_next = state;
      if (!enable) begin
         state_next = IDLE;
      end else if (boundary) begin
         state_next = HIGH;
      end else begin
         case (state)
            HIGH:    if (high_cnt == '0) state_next = LOW;
            default: state_next = state;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // Timebase, per-frame sampling and high-time countdown.
   always_ff @(posedge clk) begin
      if (rst) begin
         pre_cnt     <= '0;
         us_cnt      <= '0;
         high_cnt    <= '0;
         frame_start <= 1'b0;
         applied_pos <= MID_DEG8;
         clamped     <= 1'b0;
      end else begin
         frame_start <= 1'b0;
         if (!enable) begin
            pre_cnt <= '0;
            us_cnt  <= '0;
         end else begin
            if (pre_cnt == PRE_LAST) begin
               pre_cnt <= '0;
               us_cnt  <= (us_cnt == FRAME_LAST) ? '0 : us_cnt + FW'(1);
            end else begin
               pre_cnt <= pre_cnt + PW'(1);
            end

            if (boundary) begin
               applied_pos <= next_applied;
               clamped     <= (position > MAX_DEG8);
               frame_start <= 1'b1;
               high_cnt    <= high_load;
            end else if (state == HIGH && high_cnt != '0) begin
               high_cnt <= high_cnt - HW'(1);
            end
         end
      end
   end

   assign pwm_out = (state == HIGH);

endmodule
`default_nettype wire

// File: tb/tb_servo_pwm_driver.sv
`default_nettype none
// ============================================================================
//  Module   : tb_servo_pwm_driver
//  Purpose  : Self-checking bench for servo_pwm_driver. Two instances share
//             all inputs: one with unlimited slew and one with a 4-degree
//             slew step. TICKS = 1 and a shortened 2200 us frame keep the
//             run short while preserving the 1000..2000 us pulse range.
//  Revision : 1.0  initial release
// ============================================================================
module tb_servo_pwm_driver;

   localparam int FRAME = 2200;

   logic       clk;
   logic       rst;
   logic       enable;
   logic [7:0] position;

   logic       pwm0, fs0, cl0;
   logic [7:0] ap0;
   logic       pwm4, fs4, cl4;
   logic [7:0] ap4;

   int tests;
   int fails;
   int cyc;
   int m0, m4;
   int prev_fs;
   bit prev_valid;
   int last_wait;

   servo_pwm_driver #(
      .CLK_HZ(1_000_000), .FRAME_US(FRAME), .MIN_US(1000), .MAX_US(2000),
      .MAX_DEG(180), .SLEW_STEP(0)
   ) dut0 (
      .clk(clk), .rst(rst), .enable(enable), .position(position),
      .pwm_out(pwm0), .frame_start(fs0), .applied_pos(ap0), .clamped(cl0)
   );

   servo_pwm_driver #(
      .CLK_HZ(1_000_000), .FRAME_US(FRAME), .MIN_US(1000), .MAX_US(2000),
      .MAX_DEG(180), .SLEW_STEP(4)
   ) dut4 (
      .clk(clk), .rst(rst), .enable(enable), .position(position),
      .pwm_out(pwm4), .frame_start(fs4), .applied_pos(ap4), .clamped(cl4)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1);
   end

   // Reference: applied angle after one frame sample.
   function automatic int model_step(input int a, input int p, input int step);
      int t;
      t = (p > 180) ? 180 : p;
      if (step == 0) return t;
      if (t > a) return a + (((t - a) < step) ? (t - a) : step);
      return a - (((a - t) < step) ? (a - t) : step);
   endfunction

   function automatic int exp_pulse(input int a);
      return 1000 + (a * 1000) / 180;
   endfunction

   // Wait for the next frame start and check the per-frame sample.
   task automatic start_frame();
      int waited;
      int p;
      waited = 0;
      do begin
         @(negedge clk);
         waited++;
      end while (fs0 !== 1'b1 && waited < 3 * FRAME);
      last_wait = waited;
      tests++;
      if (fs0 !== 1'b1) begin
         fails++;
         $display("FAIL frame_start_timeout: got %b after %0d cycles, need 1", fs0, waited);
         return;
      end
      tests++;
      if (fs4 !== 1'b1) begin
         fails++;
         $display("FAIL frame_start_slew: got %b, need 1", fs4);
      end
      p  = int'(position);
      m0 = model_step(m0, p, 0);
      m4 = model_step(m4, p, 4);
      tests++;
      if (ap0 !== 8'(m0) || ap4 !== 8'(m4)) begin
         fails++;
         $display("FAIL applied_pos: got %0d/%0d, need %0d/%0d (pos %0d)", ap0, ap4, m0, m4, p);
      end
      tests++;
      if (cl0 !== (p > 180) || cl4 !== (p > 180)) begin
         fails++;
         $display("FAIL clamped: got %b/%b, need %b (pos %0d)", cl0, cl4, (p > 180), p);
      end
      if (prev_valid) begin
         tests++;
         if (cyc - prev_fs != FRAME) begin
            fails++;
            $display("FAIL frame_period: got %0d, need %0d", cyc - prev_fs, FRAME);
         end
      end
      prev_fs    = cyc;
      prev_valid = 1'b1;
   endtask

   // Count the high time of the frame just started; optionally change the
   // command once the slew-free pulse has been high for chg_at cycles.
   task automatic measure_pulse(input int chg_at, input logic [7:0] chg_pos);
      int h0, h4;
      h0 = 0;
      h4 = 0;
      for (int n = 0; n < FRAME; n++) begin
         if (n == 1) begin
            tests++;
            if (fs0 !== 1'b0 || fs4 !== 1'b0) begin
               fails++;
               $display("FAIL frame_start_width: got %b/%b one cycle later, need 0", fs0, fs4);
            end
         end
         if (pwm0 === 1'b1) h0++;
         if (pwm4 === 1'b1) h4++;
         if (pwm0 !== 1'b1 && pwm4 !== 1'b1) break;
         if (chg_at != 0 && h0 == chg_at) position = chg_pos;
         @(negedge clk);
      end
      tests++;
      if (h0 != exp_pulse(m0) || h4 != exp_pulse(m4)) begin
         fails++;
         $display("FAIL pulse_width: got %0d/%0d, need %0d/%0d", h0, h4, exp_pulse(m0), exp_pulse(m4));
      end
   endtask

   task automatic test_reset();
      rst      = 1'b1;
      enable   = 1'b0;
      position = 8'd90;
      repeat (5) @(negedge clk);
      tests++;
      if (pwm0 !== 1'b0 || fs0 !== 1'b0 || cl0 !== 1'b0 || ap0 !== 8'd90 ||
          pwm4 !== 1'b0 || fs4 !== 1'b0 || cl4 !== 1'b0 || ap4 !== 8'd90) begin
         fails++;
         $display("FAIL reset_state: got pwm %b%b fs %b%b cl %b%b ap %0d/%0d, need 0 0 0 90",
                  pwm0, pwm4, fs0, fs4, cl0, cl4, ap0, ap4);
      end
      m0 = 90;
      m4 = 90;
      prev_valid = 1'b0;
      rst    = 1'b0;
      enable = 1'b1;
   endtask

   task automatic test_nominal();
      position = 8'd90;
      repeat (2) begin
         start_frame();
         measure_pulse(0, 8'd0);
      end
   endtask

   task automatic test_clamp();
      position = 8'd200;
      start_frame();
      measure_pulse(0, 8'd0);
      position = 8'd0;
      start_frame();
      measure_pulse(0, 8'd0);
   endtask

   task automatic test_slew();
      position = 8'd90;
      start_frame();
      measure_pulse(0, 8'd0);
      position = 8'd100;
      repeat (3) begin
         start_frame();
         measure_pulse(0, 8'd0);
      end
   endtask

   task automatic test_mid_frame_change();
      position = 8'd90;
      start_frame();
      measure_pulse(700, 8'd30);
      start_frame();
      measure_pulse(0, 8'd0);
   endtask

   task automatic test_disable();
      bit bad;
      position = 8'd90;
      start_frame();
      measure_pulse(0, 8'd0);
      start_frame();
      repeat (299) @(negedge clk);
      enable = 1'b0;
      @(negedge clk);
      tests++;
      if (pwm0 !== 1'b0 || pwm4 !== 1'b0) begin
         fails++;
         $display("FAIL disable_pwm: got %b/%b, need 0", pwm0, pwm4);
      end
      bad = 1'b0;
      repeat (30) begin
         @(negedge clk);
         if (pwm0 !== 1'b0 || pwm4 !== 1'b0 || fs0 !== 1'b0 || fs4 !== 1'b0) bad = 1'b1;
      end
      tests++;
      if (bad) begin
         fails++;
         $display("FAIL disabled_idle: got activity while disabled, need pwm 0 and no frame_start");
      end
      prev_valid = 1'b0;
      enable = 1'b1;
      start_frame();
      tests++;
      if (last_wait != 1) begin
         fails++;
         $display("FAIL reenable_latency: got %0d cycles, need 1", last_wait);
      end
      measure_pulse(0, 8'd0);
   endtask

   task automatic test_reset_mid_pulse();
      position = 8'd150;
      start_frame();
      measure_pulse(0, 8'd0);
      start_frame();
      repeat (499) @(negedge clk);
      rst      = 1'b1;
      position = 8'd90;
      @(negedge clk);
      tests++;
      if (pwm0 !== 1'b0 || pwm4 !== 1'b0 || ap0 !== 8'd90 || ap4 !== 8'd90 ||
          cl0 !== 1'b0 || fs0 !== 1'b0) begin
         fails++;
         $display("FAIL reset_mid_pulse: got pwm %b/%b ap %0d/%0d, need 0 and 90",
                  pwm0, pwm4, ap0, ap4);
      end
      rst = 1'b0;
      m0 = 90;
      m4 = 90;
      prev_valid = 1'b0;
      start_frame();
      tests++;
      if (last_wait != 1) begin
         fails++;
         $display("FAIL reset_release_latency: got %0d cycles, need 1", last_wait);
      end
      measure_pulse(0, 8'd0);
   endtask

   task automatic test_random();
      repeat (6) begin
         position = 8'($urandom_range(0, 255));
         start_frame();
         measure_pulse(int'($urandom_range(0, 900)), 8'($urandom_range(0, 255)));
      end
   endtask

   initial begin
      tests = 0;
      fails = 0;
      test_reset();
      test_nominal();
      test_clamp();
      test_slew();
      test_mid_frame_change();
      test_disable();
      test_reset_mid_pulse();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
